rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
// - Round-robin arbiter and select controller for an N-way case-style data mux.
// - Shares one registered output channel between N requesters; each requester offers
//   a WIDTH-bit word with a req/ready handshake.
// - Drives the mux select (out_sel) and holds the chosen word in a 1-entry output
//   register behind a valid/ready interface.
// PARAMETERS
// - N      4  number of requesters (N >= 2)
// - WIDTH  4  data width per requester
// - SEL_W  $clog2(N)  select width (derived, not overridden)
// PORTS
// - clk        in   1        single clock, rising edge
// - rst        in   1        asynchronous, active-high reset
// - req        in   N        req[i]=1: requester i offers req_data word i
// - req_data   in   N*WIDTH  word i at [i*WIDTH +: WIDTH]
// - req_ready  out  N        one-hot or zero; word i accepted when req[i] & req_ready[i]
// - out_valid  out  1        output register holds a word
// - out_data   out  WIDTH    registered muxed word
// - out_sel    out  SEL_W    index of requester that supplied out_data
// - out_ready  in   1        consumer accepts when out_valid & out_ready
// BEHAVIOUR
// - Reset (async assert, sync release) values:
//   - out_valid=0, out_data=0, out_sel=0
//   - ptr=0 (requester 0 highest priority); FSM=IDLE
//   - req_ready=0 while rst=1
// - FSM IDLE (out_valid=0):
//   - Any req -> grant first requesting index at or after ptr, wrapping N-1 -> 0.
//   - req_ready[g]=1 in the same cycle; next edge loads out_data=word g, out_sel=g,
//     out_valid=1, ptr=(g+1) mod N; go to BUSY.
// - FSM BUSY (out_valid=1):
//   - out_data/out_sel held stable while out_ready=0; req_ready=0.
//   - out_ready=1 with another req: re-arbitrate in the same cycle, load the new word,
//     stay BUSY (full throughput, 1 word/cycle).
//   - out_ready=1 with no req: out_valid=0 next edge; go to IDLE.
// - Rules:
//   - Latency: accept edge -> out_valid=1 on the same edge (1-cycle register stage).
//   - ptr advances only on an accepted word; never during backpressure.
//   - req deasserted by a requester before acceptance is simply not granted; no error.
//   - Single active requester is granted every cycle (work-conserving).
//   - req_ready is combinational from req, ptr, FSM state and out_ready; no path from
//     req_data.
//   - Reset mid-transfer drops the held word; no partial output.
// CONFIGURATION
// - RR_ARB_BURST_LOCK_EN defined:
//   - Adds input req_last[N] (1 bit per requester).
//   - Accepting a word with req_last[g]=0 locks the grant to g; only g is eligible and
//     ptr does not advance.
//   - Lock releases on acceptance of a word with req_last[g]=1; ptr=(g+1) mod N.
//   - While locked, req[g]=0 produces no grant (others stay blocked).
//   - Reset clears the lock.
// - RR_ARB_BURST_LOCK_EN undefined:
//   - No req_last port; every accepted word re-arbitrates.
// TESTING (N=4, WIDTH=4, req_data words 0..3 = 4'h1,4'h2,4'h3,4'h4)
// - Reset: rst=1, req=4'b1111 -> req_ready=0, out_valid=0, out_data=0, out_sel=0.
// - Fairness: req=4'b1111, out_ready=1 for 5 cycles -> out_sel 0,1,2,3,0;
//   out_data 1,2,3,4,1; one word/cycle.
// - Backpressure: out_ready=0 for 3 cycles after out_sel=1 captured ->
//   out_data=4'h2 held, req_ready=0, next grant is 2.
// - Single requester: req=4'b0100 continuously, out_ready=1 -> out_sel=2 every cycle,
//   no bubbles.
// - Async reset while out_valid=1 -> out_valid=0 before next edge; after release
//   req=4'b1010 grants 1 first.
// - Lock (macro on): req=4'b0011, req_last[0] high on 3rd beat -> out_sel 0,0,0,1.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin grant and select for an N-way mux feeding a 1-entry output register.
// Latency: the edge that accepts a word also loads out_data/out_sel and raises out_valid (1 register stage).
// Backpressure: out_ready=0 holds the register and forces req_ready=0; define RR_ARB_BURST_LOCK_EN for burst lock.
module rr_mux_arbiter #(
  parameter  int N     = 4,
  parameter  int WIDTH = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
`ifdef RR_ARB_BURST_LOCK_EN
  ,
  input  logic [N-1:0]       req_last
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] grant;
  logic [N-1:0]     eligible;
  logic             found;
  logic             accept;
  logic             hold_ptr;

`ifdef RR_ARB_BURST_LOCK_EN
  logic             locked_q;
  logic [SEL_W-1:0] lock_idx_q;

  // While locked only the burst owner is eligible; if it drops req nobody is granted.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = req[i] & (~locked_q | (lock_idx_q == SEL_W'(i)));
    end
  end

  assign hold_ptr = ~req_last[grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else if (accept) begin
      locked_q   <= hold_ptr;
      lock_idx_q <= grant;
    end
  end
`else
  assign eligible = req;
  assign hold_ptr = 1'b0;
`endif

  // First eligible requester at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && eligible[(int'(ptr_q) + k) % N]) begin
        grant = SEL_W'((int'(ptr_q) + k) % N);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (found) accept  = 1'b1;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) accept = 1'b0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else if (accept) begin
      out_data <= req_data[int'(grant)*WIDTH +: WIDTH];
      out_sel  <= grant;
      if (!hold_ptr) ptr_q <= (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign out_valid = (state_q == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_rr_mux_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 4;
  localparam int SEL_W = 2;
`ifdef RR_ARB_BURST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;
  logic [N-1:0]       req_last;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: what the output register should hold, and the rotating priority.
  bit             m_valid;
  logic [WIDTH-1:0] m_data;
  int             m_sel;
  int             m_ptr;
  bit             m_locked;
  int             m_lock_idx;
  int             exp_g;
  logic [N-1:0]   exp_ready;
  logic [WIDTH-1:0] exp_word;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_ARB_BURST_LOCK_EN
    ,
    .req_last  (req_last)
`endif
  );

  task automatic model_reset();
    m_valid    = 1'b0;
    m_data     = '0;
    m_sel      = 0;
    m_ptr      = 0;
    m_locked   = 1'b0;
    m_lock_idx = 0;
  endtask

  // Called at posedge+1 with inputs already driven; waits to the negedge and predicts this cycle.
  task automatic step_eval();
    int i;
    @(negedge clk);
    exp_g = -1;
    for (int d = 0; d < N; d++) begin
      i = (m_ptr + d) % N;
      if (exp_g < 0 && req[i] && (!m_locked || i == m_lock_idx)) exp_g = i;
    end
    exp_ready = '0;
    if (!rst && exp_g >= 0 && (!m_valid || out_ready)) exp_ready[exp_g] = 1'b1;
    if (exp_g >= 0) exp_word = req_data[exp_g*WIDTH +: WIDTH];
    else            exp_word = '0;
  endtask

  task automatic step_commit();
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (exp_ready != '0) begin
      m_valid = 1'b1;
      m_data  = exp_word;
      m_sel   = exp_g;
      if (LOCK && !req_last[exp_g]) begin
        m_locked   = 1'b1;
        m_lock_idx = exp_g;
      end else begin
        m_locked = 1'b0;
        m_ptr    = (exp_g + 1) % N;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    model_reset();
    @(negedge clk);
    total_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b exp 0000", req_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 4'h0) $display("FAIL reset_out_data got %h exp 0", out_data); else pass_cnt++;
    total_cnt++; if (out_sel !== 2'd0) $display("FAIL reset_out_sel got %0d exp 0", out_sel); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fairness();
    int seq[5] = '{0, 1, 2, 3, 0};
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      step_eval();
      total_cnt++; if (req_ready !== exp_ready) $display("FAIL fair_req_ready k=%0d got %b exp %b", k, req_ready, exp_ready); else pass_cnt++;
      if (k > 0) begin
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL fair_out_valid k=%0d got %b exp 1", k, out_valid); else pass_cnt++;
        total_cnt++; if (out_sel !== SEL_W'(seq[k-1])) $display("FAIL fair_out_sel k=%0d got %0d exp %0d", k, out_sel, seq[k-1]); else pass_cnt++;
        total_cnt++; if (out_data !== WIDTH'(seq[k-1] + 1)) $display("FAIL fair_out_data k=%0d got %h exp %0h", k, out_data, seq[k-1] + 1); else pass_cnt++;
      end
      step_commit();
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step_eval();
      step_commit();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_eval();
      total_cnt++; if (out_data !== 4'h2) $display("FAIL bp_out_data k=%0d got %h exp 2", k, out_data); else pass_cnt++;
      total_cnt++; if (out_sel !== 2'd1) $display("FAIL bp_out_sel k=%0d got %0d exp 1", k, out_sel); else pass_cnt++;
      total_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_req_ready k=%0d got %b exp 0000", k, req_ready); else pass_cnt++;
      total_cnt++; if (req_ready !== exp_ready) $display("FAIL bp_model k=%0d got %b exp %b", k, req_ready, exp_ready); else pass_cnt++;
      step_commit();
    end
    out_ready = 1'b1;
    step_eval();
    total_cnt++; if (req_ready !== 4'b0100) $display("FAIL bp_next_grant got %b exp 0100", req_ready); else pass_cnt++;
    step_commit();
  endtask

  task automatic test_single();
    req       = 4'b0100;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step_eval();
      total_cnt++; if (req_ready !== 4'b0100) $display("FAIL single_req_ready k=%0d got %b exp 0100", k, req_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1 || out_sel !== 2'd2) $display("FAIL single_out k=%0d got v=%b sel=%0d exp v=1 sel=2", k, out_valid, out_sel); else pass_cnt++;
      step_commit();
    end
  endtask

  task automatic test_async_reset();
    req       = 4'b1111;
    out_ready = 1'b0;
    step_eval();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL ar_pre_valid got %b exp 1", out_valid); else pass_cnt++;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 4'b0000) $display("FAIL ar_req_ready got %b exp 0000", req_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req       = 4'b1010;
    out_ready = 1'b1;
    step_eval();
    total_cnt++; if (req_ready !== 4'b0010) $display("FAIL ar_first_grant got %b exp 0010", req_ready); else pass_cnt++;
    step_commit();
    step_eval();
    total_cnt++; if (out_sel !== 2'd1 || out_data !== 4'h2) $display("FAIL ar_out got sel=%0d data=%h exp sel=1 data=2", out_sel, out_data); else pass_cnt++;
    step_commit();
  endtask

`ifdef RR_ARB_BURST_LOCK_EN
  task automatic test_lock();
    int seq[4] = '{0, 0, 0, 1};
    pulse_reset();
    req       = 4'b0011;
    out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      req_last = 4'b1110;
      if (k == 2) req_last = 4'b1111;
      step_eval();
      if (k > 0) begin
        total_cnt++; if (out_sel !== SEL_W'(seq[k-1])) $display("FAIL lock_out_sel k=%0d got %0d exp %0d", k, out_sel, seq[k-1]); else pass_cnt++;
      end
      total_cnt++; if (req_ready !== exp_ready) $display("FAIL lock_req_ready k=%0d got %b exp %b", k, req_ready, exp_ready); else pass_cnt++;
      step_commit();
    end
    req_last = '1;
  endtask
`endif

  task automatic test_random();
    pulse_reset();
    for (int k = 0; k < 400; k++) begin
      req       = N'($urandom);
      req_data  = (N*WIDTH)'($urandom);
      req_last  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      step_eval();
      total_cnt++; if (req_ready !== exp_ready) $display("FAIL rnd_req_ready k=%0d got %b exp %b", k, req_ready, exp_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== m_valid) $display("FAIL rnd_out_valid k=%0d got %b exp %b", k, out_valid, m_valid); else pass_cnt++;
      if (m_valid) begin
        total_cnt++; if (out_data !== m_data) $display("FAIL rnd_out_data k=%0d got %h exp %h", k, out_data, m_data); else pass_cnt++;
        total_cnt++; if (out_sel !== SEL_W'(m_sel)) $display("FAIL rnd_out_sel k=%0d got %0d exp %0d", k, out_sel, m_sel); else pass_cnt++;
      end
      step_commit();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    req_last  = '1;
    req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    model_reset();
    #1;
    test_reset();
    test_fairness();
    test_backpressure();
    test_single();
    test_async_reset();
`ifdef RR_ARB_BURST_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
